ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width of all ports.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive instruction-port losses before the instruction port is forced to win.
REQ-003 SHALL have ports:
- sysClk  in  1  clock; all logic on rising edge.
- sysRes  in  1  synchronous, active-high reset.
REQ-004 SHALL have the instruction-port ports:
- instrReq  in  1  fetch request.
- instrAddr  in  ADDR_W  fetch address.
- instrGnt  out  1  fetch accepted this cycle.
- instrValid  out  1  fetch data valid.
- instrData  out  32  fetch data.
REQ-005 SHALL have the data-port ports:
- dataReq  in  1  load/store request.
- dataWe  in  1  store when 1.
- dataAddr  in  ADDR_W  address.
- dataWData  in  32  store data.
- dataMask  in  4  byte enables.
- dataGnt  out  1  accepted.
- dataValid  out  1  response.
- dataRData  out  32  load data.
REQ-006 SHALL have the RAM-port ports:
- ramAddr  out  ADDR_W  address.
- ramWe  out  1  write enable.
- ramWData  out  32  write data.
- ramMask  out  4  byte enables.
- ramRData  in  32  read data, one-cycle synchronous latency.

Function
REQ-007 SHALL grant at most one port per cycle; the grant is combinational from the requests and the current starvation count.
REQ-008 SHALL give the data port priority when both ports request, unless starveCnt equals STARVE_MAX, in which case the instruction port SHALL win.
REQ-009 SHALL drive ramAddr/ramWe/ramWData/ramMask from the granted port in the grant cycle N.
REQ-010 SHALL drive ramWe=0 and ramMask=0 when no port is granted, and when the instruction port is granted.
REQ-011 SHALL register the response owner (state RESP_NONE / RESP_INSTR / RESP_DATA_RD / RESP_DATA_WR) at the end of cycle N.
REQ-012 SHALL pulse the owner's valid in cycle N+1 (latency exactly 1).
REQ-013 SHALL make instrData=ramRData in RESP_INSTR; dataRData=ramRData in RESP_DATA_RD; dataRData=0 in RESP_DATA_WR (write acknowledge).
REQ-014 SHALL hold the data output of a port at 0 whenever that port's valid is 0.
REQ-015 SHALL permit a new grant in N+1 while the N response is returned, giving fully pipelined back-to-back accesses with no bubble.
REQ-016 SHALL increment starveCnt when instrReq=1 and the data port wins, saturating at STARVE_MAX.
REQ-017 SHALL clear starveCnt to 0 on any instruction grant, and hold it when instrReq=0.
REQ-018 SHALL hold a requester's inputs stable until that requester is granted; a request dropped before grant SHALL be discarded silently.
REQ-019 SHALL treat STARVE_MAX=0 as strict round-robin: alternate priority whenever both ports request.

Reset
REQ-020 SHALL, while sysRes=1: drive all outputs to 0, state=RESP_NONE, starveCnt=0, and issue no grants.
REQ-021 SHALL discard any in-flight response when reset asserts mid-access; no valid appears in the cycle after reset release.

Configuration
REQ-022 SHALL, when macro RAM_ARB_STATS_EN is defined, add 32-bit wrapping output counters:
- instrGrantCnt: number of instruction grants.
- dataGrantCnt: number of data grants.
- conflictCnt: cycles with both requests asserted.
REQ-023 SHALL, when RAM_ARB_STATS_EN is undefined, keep the same ports tied to 0 with no counter logic.

Structure
REQ-024 SHALL place the response-state encodings (RESP_NONE, RESP_INSTR, RESP_DATA_RD, RESP_DATA_WR) in the shared constants header.
REQ-025 SHALL implement starvation tracking in sub-module arb_starve_counter (inputs: instrReq, loss, instrGnt; output: forced).

Verification
REQ-026 SHALL cover: instrReq only, addr 0x10, RAM word 0xDEADBEEF -> instrGnt in N, instrValid with instrData=0xDEADBEEF in N+1.
REQ-027 SHALL cover: both ports requesting continuously with STARVE_MAX=4 -> 4 data grants, then 1 instruction grant, repeating.
REQ-028 SHALL cover: data store to 0x20, data 0x12345678, mask 0b0011, then load from 0x20 with prior word 0 -> dataValid with 0 (write ack), then 0x00005678.
REQ-029 SHALL cover: fetches to 0x0, 0x4, 0x8 on consecutive cycles -> three grants and three valids on consecutive cycles, no bubble.
REQ-030 SHALL cover: sysRes asserted in the cycle after a data-load grant -> no dataValid, all outputs 0, starveCnt=0.
REQ-031 SHALL cover, with RAM_ARB_STATS_EN defined: 10 conflict cycles -> conflictCnt=10, and instrGrantCnt + dataGrantCnt equal to the total number of grants.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the instruction/data RAM arbiter.
package ram_arbiter_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [1:0] {
      RESP_NONE    = 2'd0,
      RESP_INSTR   = 2'd1,
      RESP_DATA_RD = 2'd2,
      RESP_DATA_WR = 2'd3
   } resp_e;

   typedef struct packed {
      logic              we;
      logic [MASK_W-1:0] mask;
      logic [DATA_W-1:0] wdata;
   } ram_wr_t;

   // A limit of 0 means strict alternation, i.e. forced after a single loss.
   function automatic int unsigned starve_limit(input int unsigned smax);
      return (smax == 0) ? 1 : smax;
   endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive instruction-port losses; asserts forced at the limit.
module arb_starve_counter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic sysClk,
   input  logic sysRes,
   input  logic instrReq,
   input  logic loss,
   input  logic instrGnt,
   output logic forced
);

   localparam int unsigned LIM = starve_limit(STARVE_MAX);
   localparam int unsigned CW  = $clog2(LIM + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (instrGnt) begin
         cnt_d = '0;
      end else if (instrReq && loss && (cnt_q != CW'(LIM))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge sysClk) begin
      if (sysRes) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign forced = (cnt_q == CW'(LIM));

endmodule

// File: rtl/ram_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single synchronous RAM port.
// Optional statistics counters are enabled with macro RAM_ARB_STATS_EN.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              sysClk,
   input  logic              sysRes,
   input  logic              instrReq,
   input  logic [ADDR_W-1:0] instrAddr,
   output logic              instrGnt,
   output logic              instrValid,
   output logic [DATA_W-1:0] instrData,
   input  logic              dataReq,
   input  logic              dataWe,
   input  logic [ADDR_W-1:0] dataAddr,
   input  logic [DATA_W-1:0] dataWData,
   input  logic [MASK_W-1:0] dataMask,
   output logic              dataGnt,
   output logic              dataValid,
   output logic [DATA_W-1:0] dataRData,
   output logic [ADDR_W-1:0] ramAddr,
   output logic              ramWe,
   output logic [DATA_W-1:0] ramWData,
   output logic [MASK_W-1:0] ramMask,
   input  logic [DATA_W-1:0] ramRData,
   output logic [CNT_W-1:0]  instrGrantCnt,
   output logic [CNT_W-1:0]  dataGrantCnt,
   output logic [CNT_W-1:0]  conflictCnt
);

   logic    forced;
   logic    instr_win, data_win;
   resp_e   state_q, state_d;
   ram_wr_t ram_wr;

   // Data port has priority unless the fetch port has starved to the limit.
   always_comb begin
      instr_win = !sysRes && instrReq && (!dataReq || forced);
      data_win  = !sysRes && dataReq && !instr_win;
   end

   assign instrGnt = instr_win;
   assign dataGnt  = data_win;

   arb_starve_counter #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .sysClk  (sysClk),
      .sysRes  (sysRes),
      .instrReq(instrReq),
      .loss    (data_win),
      .instrGnt(instr_win),
      .forced  (forced)
   );

   // Fetches never write, so only the data port may drive we/mask.
   always_comb begin
      ramAddr = '0;
      ram_wr  = '0;
      if (data_win) begin
         ramAddr = dataAddr;
         ram_wr  = '{we: dataWe, mask: dataMask, wdata: dataWData};
      end else if (instr_win) begin
         ramAddr = instrAddr;
      end
   end

   assign ramWe    = ram_wr.we;
   assign ramMask  = ram_wr.mask;
   assign ramWData = ram_wr.wdata;

   always_comb begin
      state_d = RESP_NONE;
      if (data_win) begin
         state_d = dataWe ? RESP_DATA_WR : RESP_DATA_RD;
      end else if (instr_win) begin
         state_d = RESP_INSTR;
      end
   end

   always_ff @(posedge sysClk) begin
      if (sysRes) begin
         state_q <= RESP_NONE;
      end else begin
         state_q <= state_d;
      end
   end

   // Responses are suppressed while reset is held so in-flight accesses vanish.
   assign instrValid = !sysRes && (state_q == RESP_INSTR);
   assign dataValid  = !sysRes && ((state_q == RESP_DATA_RD) || (state_q == RESP_DATA_WR));
   assign instrData  = instrValid ? ramRData : '0;
   assign dataRData  = (!sysRes && (state_q == RESP_DATA_RD)) ? ramRData : '0;

`ifdef RAM_ARB_STATS_EN
   logic [CNT_W-1:0] icnt_q, dcnt_q, ccnt_q;

   always_ff @(posedge sysClk) begin
      if (sysRes) begin
         icnt_q <= '0;
         dcnt_q <= '0;
         ccnt_q <= '0;
      end else begin
         if (instr_win) icnt_q <= icnt_q + CNT_W'(1);
         if (data_win) dcnt_q <= dcnt_q + CNT_W'(1);
         if (instrReq && dataReq) ccnt_q <= ccnt_q + CNT_W'(1);
      end
   end

   assign instrGrantCnt = sysRes ? '0 : icnt_q;
   assign dataGrantCnt  = sysRes ? '0 : dcnt_q;
   assign conflictCnt   = sysRes ? '0 : ccnt_q;
`else
   assign instrGrantCnt = '0;
   assign dataGrantCnt  = '0;
   assign conflictCnt   = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed table, corner sequences, random traffic.
module tb_ram_arbiter;

   localparam int unsigned SMAX = 4;
   localparam int unsigned LIM  = (SMAX == 0) ? 1 : SMAX;

   logic        sysClk, sysRes;
   logic        instrReq, instrGnt, instrValid;
   logic [31:0] instrAddr, instrData;
   logic        dataReq, dataWe, dataGnt, dataValid;
   logic [31:0] dataAddr, dataWData, dataRData;
   logic [3:0]  dataMask, ramMask;
   logic [31:0] ramAddr, ramWData, ramRData;
   logic        ramWe;
   logic [31:0] instrGrantCnt, dataGrantCnt, conflictCnt;

   ram_arbiter #(.ADDR_W(32), .STARVE_MAX(SMAX)) dut (
      .sysClk(sysClk), .sysRes(sysRes),
      .instrReq(instrReq), .instrAddr(instrAddr), .instrGnt(instrGnt),
      .instrValid(instrValid), .instrData(instrData),
      .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr),
      .dataWData(dataWData), .dataMask(dataMask), .dataGnt(dataGnt),
      .dataValid(dataValid), .dataRData(dataRData),
      .ramAddr(ramAddr), .ramWe(ramWe), .ramWData(ramWData), .ramMask(ramMask),
      .ramRData(ramRData),
      .instrGrantCnt(instrGrantCnt), .dataGrantCnt(dataGrantCnt), .conflictCnt(conflictCnt)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   // RAM with one-cycle synchronous read, byte-masked write
   logic [31:0] mem [64];
   always @(posedge sysClk) begin
      if (ramWe) begin
         for (int b = 0; b < 4; b++)
            if (ramMask[b]) mem[ramAddr[7:2]][8*b +: 8] <= ramWData[8*b +: 8];
      end
      ramRData <= mem[ramAddr[7:2]];
   end

   // Reference model state
   logic [31:0] refmem [64];
   int unsigned m_starve;
   int          m_kind;      // 0 none, 1 fetch, 2 load, 3 store
   logic [31:0] m_data;
   logic [31:0] m_icnt, m_dcnt, m_ccnt;
   logic        m_ig, m_dg;

   int checks, errors;
   logic        a_ig, a_dg, a_iv, a_dv;
   logic [31:0] a_id, a_dd, a_icnt, a_dcnt, a_ccnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // One clock: drive, check mid-cycle against the model, then advance the model.
   task automatic cycle(input logic rst, input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dwe, input logic [31:0] daddr,
                        input logic [31:0] wdata, input logic [3:0] mask);
      logic        ewe, eiv, edv;
      logic [3:0]  emask;
      logic [31:0] eaddr, eid, edd, ei, ed, ec;
      sysRes = rst; instrReq = ireq; instrAddr = iaddr;
      dataReq = dreq; dataWe = dwe; dataAddr = daddr; dataWData = wdata; dataMask = mask;
      #4;
      m_ig = !rst && ireq && (!dreq || (m_starve >= LIM));
      m_dg = !rst && dreq && !m_ig;
      ewe = m_dg && dwe;
      emask = m_dg ? mask : 4'h0;
      eaddr = m_dg ? daddr : iaddr;
      eiv = !rst && (m_kind == 1);
      edv = !rst && (m_kind >= 2);
      eid = eiv ? m_data : 32'h0;
      edd = (!rst && (m_kind == 2)) ? m_data : 32'h0;
`ifdef RAM_ARB_STATS_EN
      ei = rst ? 32'h0 : m_icnt; ed = rst ? 32'h0 : m_dcnt; ec = rst ? 32'h0 : m_ccnt;
`else
      ei = 32'h0; ed = 32'h0; ec = 32'h0;
`endif
      a_ig = instrGnt; a_dg = dataGnt; a_iv = instrValid; a_dv = dataValid;
      a_id = instrData; a_dd = dataRData;
      a_icnt = instrGrantCnt; a_dcnt = dataGrantCnt; a_ccnt = conflictCnt;
      chk("instrGnt", 32'(instrGnt), 32'(m_ig));
      chk("dataGnt", 32'(dataGnt), 32'(m_dg));
      chk("ramWe", 32'(ramWe), 32'(ewe));
      chk("ramMask", 32'(ramMask), 32'(emask));
      if (m_ig || m_dg) chk("ramAddr", ramAddr, eaddr);
      if (m_dg) chk("ramWData", ramWData, wdata);
      chk("instrValid", 32'(instrValid), 32'(eiv));
      chk("instrData", instrData, eid);
      chk("dataValid", 32'(dataValid), 32'(edv));
      chk("dataRData", dataRData, edd);
      chk("instrGrantCnt", instrGrantCnt, ei);
      chk("dataGrantCnt", dataGrantCnt, ed);
      chk("conflictCnt", conflictCnt, ec);
      @(posedge sysClk);
      if (rst) begin
         m_starve = 0; m_kind = 0; m_icnt = 0; m_dcnt = 0; m_ccnt = 0;
      end else begin
         if (ireq && dreq) m_ccnt++;
         if (m_ig) begin
            m_icnt++; m_starve = 0; m_kind = 1; m_data = refmem[iaddr[7:2]];
         end else if (m_dg) begin
            m_dcnt++;
            if (ireq && m_starve < LIM) m_starve++;
            m_kind = dwe ? 3 : 2;
            m_data = refmem[daddr[7:2]];
            if (dwe) refmem[daddr[7:2]] = merge(refmem[daddr[7:2]], wdata, mask);
         end else begin
            m_kind = 0;
         end
      end
      #1;
   endtask

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq, dwe;
      logic [31:0] daddr, wdata;
      logic [3:0]  mask;
      logic        eig, edg, eiv;
      logic [31:0] eid;
      logic        edv;
      logic [31:0] edd;
   } vec_t;

   vec_t tbl [9];
   logic pi, pd, pwe, rr;
   logic [31:0] pia, pda, pwd;
   logic [3:0]  pm;

   initial begin
      checks = 0; errors = 0;
      m_starve = 0; m_kind = 0; m_data = 32'h0; m_icnt = 0; m_dcnt = 0; m_ccnt = 0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'hA000_0000 + 32'(i);
         refmem[i] = 32'hA000_0000 + 32'(i);
      end
      mem[4] = 32'hDEADBEEF; refmem[4] = 32'hDEADBEEF;
      mem[8] = 32'h0;        refmem[8] = 32'h0;

      //        ireq  iaddr     dreq  dwe   daddr     wdata          mask    ig    dg    iv    idata          dv    ddata
      tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h20, 32'h12345678, 4'h3, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h20, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
      tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00005678};
      tbl[5] = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[6] = '{1'b1, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'hA0000000, 1'b0, 32'h0};
      tbl[7] = '{1'b1, 32'h8,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'hA0000001, 1'b0, 32'h0};
      tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 32'hA0000002, 1'b0, 32'h0};

      // reset with requests pending: everything must stay quiet
      cycle(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
      cycle(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);

      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].dwe,
               tbl[i].daddr, tbl[i].wdata, tbl[i].mask);
         chk($sformatf("tbl%0d_ig", i), 32'(a_ig), 32'(tbl[i].eig));
         chk($sformatf("tbl%0d_dg", i), 32'(a_dg), 32'(tbl[i].edg));
         chk($sformatf("tbl%0d_iv", i), 32'(a_iv), 32'(tbl[i].eiv));
         chk($sformatf("tbl%0d_id", i), a_id, tbl[i].eid);
         chk($sformatf("tbl%0d_dv", i), 32'(a_dv), 32'(tbl[i].edv));
         chk($sformatf("tbl%0d_dd", i), a_dd, tbl[i].edd);
      end

      // continuous contention: four data wins then one forced fetch
      for (int k = 0; k < 15; k++) begin
         cycle(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
         chk($sformatf("starve%0d_ig", k), 32'(a_ig), 32'((k % 5) == 4));
      end

      // build up starvation, grant a load, then reset mid-access
      cycle(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
      cycle(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
      cycle(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
      chk("ld_before_rst_dg", 32'(a_dg), 32'h1);
      cycle(1'b1, 1'b1, 32'h30, 1'b1, 1'b1, 32'h44, 32'h5, 4'hF);
      chk("rst_dv", 32'(a_dv), 32'h0);
      chk("rst_dd", a_dd, 32'h0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("post_rst_dv", 32'(a_dv), 32'h0);
      chk("post_rst_iv", 32'(a_iv), 32'h0);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b1, 32'h34, 1'b1, 1'b0, 32'h48, 32'h0, 4'hF);
         chk($sformatf("post_rst_starve%0d_ig", k), 32'(a_ig), 32'((k % 5) == 4));
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`ifdef RAM_ARB_STATS_EN
      chk("stats_conflict10", a_ccnt, 32'd10);
      chk("stats_grant_sum", a_icnt + a_dcnt, 32'd10);
`else
      chk("stats_conflict_tied", a_ccnt, 32'd0);
      chk("stats_grant_tied", a_icnt + a_dcnt, 32'd0);
`endif

      // random traffic; requests are held until granted or occasionally dropped
      pi = 1'b0; pd = 1'b0; pia = 32'h0; pda = 32'h0; pwd = 32'h0; pwe = 1'b0; pm = 4'h0;
      for (int n = 0; n < 400; n++) begin
         if (pi && ($urandom_range(0, 9) == 0)) pi = 1'b0;
         if (pd && ($urandom_range(0, 9) == 0)) pd = 1'b0;
         if (!pi && $urandom_range(0, 1) == 1) begin
            pi = 1'b1; pia = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         end
         if (!pd && $urandom_range(0, 1) == 1) begin
            pd = 1'b1; pda = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            pwe = 1'($urandom_range(0, 1)); pwd = $urandom; pm = 4'($urandom_range(0, 15));
         end
         rr = ($urandom_range(0, 99) == 0);
         cycle(rr, pi, pia, pd, pwe, pda, pwd, pm);
         if (m_ig) pi = 1'b0;
         if (m_dg) pd = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
